seq_alu: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle RV32 ALU.
- Executes every base integer op and adds iterative multiply/divide (RV32M subset).
- Sits between decode/operand fetch and writeback in the multi-cycle core; stalls the pipe through a valid/ready handshake.
- Base ops complete in 1 cycle; M ops take WIDTH iteration cycles.

---
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_alu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle RV32I/M ALU: single-cycle base ops, iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             illegal
);

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_AND   = 5'b00010;
   localparam logic [4:0] OP_OR    = 5'b00011;
   localparam logic [4:0] OP_XOR   = 5'b00100;
   localparam logic [4:0] OP_SLT   = 5'b00101;
   localparam logic [4:0] OP_SLL   = 5'b00110;
   localparam logic [4:0] OP_SRL   = 5'b00111;
   localparam logic [4:0] OP_SRA   = 5'b01000;
   localparam logic [4:0] OP_SLTU  = 5'b01001;
   localparam logic [4:0] OP_MUL   = 5'b10000;
   localparam logic [4:0] OP_MULH  = 5'b10001;
   localparam logic [4:0] OP_MULHU = 5'b10010;
   localparam logic [4:0] OP_DIV   = 5'b10011;
   localparam logic [4:0] OP_DIVU  = 5'b10100;
   localparam logic [4:0] OP_REM   = 5'b10101;
   localparam logic [4:0] OP_REMU  = 5'b10110;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic             accept, is_mul, is_div, sgn, a_neg, b_neg, last;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] base_y;
   logic             base_ill;

   // iteration state: hi/lo is the product accumulator or remainder/dividend pair
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] hi, lo, opnd, a_q;
   logic [4:0]       op_q;
   logic             neg_q, neg_r, div0;

   logic [WIDTH:0]     msum, dsh;
   logic [WIDTH-1:0]   mhi_n, mlo_n, dhi_n, dlo_n, ddiff, q_s, r_s, mres, dres;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic               dge, is_rem;

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE) && !reset;
   assign accept    = in_valid && in_ready;
   assign zero      = (y == '0);
   assign last      = (cnt == SHW'(WIDTH-1));

   assign is_mul = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
   assign is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   assign sgn    = is_mul ? (op != OP_MULHU) : ((op == OP_DIV) || (op == OP_REM));
   assign a_neg  = sgn && a[WIDTH-1];
   assign b_neg  = sgn && b[WIDTH-1];
   assign mag_a  = a_neg ? -a : a;
   assign mag_b  = b_neg ? -b : b;

   always_comb begin
      base_y   = '0;
      base_ill = 1'b0;
      case (op)
         OP_ADD:  base_y = a + b;
         OP_SUB:  base_y = a - b;
         OP_AND:  base_y = a & b;
         OP_OR:   base_y = a | b;
         OP_XOR:  base_y = a ^ b;
         OP_SLT:  base_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: base_y = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  base_y = a << b[SHW-1:0];
         OP_SRL:  base_y = a >> b[SHW-1:0];
         OP_SRA:  base_y = $signed(a) >>> b[SHW-1:0];
         default: base_ill = 1'b1;
      endcase
   end

   // one shift-add step: add multiplicand on lo[0], shift {hi,lo} right
   assign msum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign mhi_n = msum[WIDTH:1];
   assign mlo_n = {msum[0], lo[WIDTH-1:1]};
   assign prod   = {mhi_n, mlo_n};
   assign prod_s = neg_q ? -prod : prod;
   assign mres   = (op_q == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

   // one restoring step; the partial remainder stays below the divisor so W bits suffice
   assign dsh    = {hi, lo[WIDTH-1]};
   assign dge    = dsh >= {1'b0, opnd};
   assign ddiff  = dsh[WIDTH-1:0] - opnd;
   assign dhi_n  = dge ? ddiff : dsh[WIDTH-1:0];
   assign dlo_n  = {lo[WIDTH-2:0], dge};
   assign q_s    = neg_q ? -dlo_n : dlo_n;
   assign r_s    = neg_r ? -dhi_n : dhi_n;
   assign is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
   assign dres   = div0 ? (is_rem ? a_q : '1) : (is_rem ? r_s : q_s);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = is_mul ? MUL : (is_div ? DIV : DONE);
         MUL:  if (last) state_nxt = DONE;
         DIV:  if (last) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y       <= '0;
         illegal <= 1'b0;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         opnd    <= '0;
         a_q     <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q  <= op;
               a_q   <= a;
               cnt   <= '0;
               hi    <= '0;
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
               div0  <= (b == '0);
               if (is_mul) begin
                  opnd <= mag_a;
                  lo   <= mag_b;
               end else if (is_div) begin
                  opnd <= mag_b;
                  lo   <= mag_a;
               end else begin
                  y       <= base_y;
                  illegal <= base_ill;
               end
            end
            MUL: begin
               hi  <= mhi_n;
               lo  <= mlo_n;
               cnt <= cnt + SHW'(1);
               if (last) begin
                  y       <= mres;
                  illegal <= 1'b0;
               end
            end
            DIV: begin
               hi  <= dhi_n;
               lo  <= dlo_n;
               cnt <= cnt + SHW'(1);
               if (last) begin
                  y       <= dres;
                  illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results are queued when an op is
// driven and popped when the result handshake completes.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
   logic [4:0]  op;
   logic [31:0] a, b, y;

   int vectors = 0, miscompares = 0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .illegal(illegal)
   );

   // reference: {illegal, y} from wide integer arithmetic
   function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z);
      longint sx, sz;
      logic [63:0] p;
      logic [31:0] r;
      logic ill;
      sx = longint'($signed(x));
      sz = longint'($signed(z));
      r = '0;
      ill = 1'b0;
      case (o)
         5'h00: r = x + z;
         5'h01: r = x - z;
         5'h02: r = x & z;
         5'h03: r = x | z;
         5'h04: r = x ^ z;
         5'h05: r = (sx < sz) ? 32'd1 : 32'd0;
         5'h06: r = x << z[4:0];
         5'h07: r = x >> z[4:0];
         5'h08: r = 32'($signed(x) >>> z[4:0]);
         5'h09: r = (x < z) ? 32'd1 : 32'd0;
         5'h10: begin p = sx * sz; r = p[31:0]; end
         5'h11: begin p = sx * sz; r = p[63:32]; end
         5'h12: begin p = {32'd0, x} * {32'd0, z}; r = p[63:32]; end
         5'h13: r = (z == 0) ? 32'hFFFF_FFFF : 32'(sx / sz);
         5'h14: r = (z == 0) ? 32'hFFFF_FFFF : x / z;
         5'h15: r = (z == 0) ? x : 32'(sx % sz);
         5'h16: r = (z == 0) ? x : x % z;
         default: ill = 1'b1;
      endcase
      return {ill, r};
   endfunction

   function automatic int exp_lat(input logic [4:0] o);
      return (o inside {[5'h10:5'h16]}) ? 33 : 1;
   endfunction

   // drive one op, push its expectation, wait (bounded) for out_valid
   task automatic run_op(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         output int lat, output logic [31:0] ry, output logic rill,
                         output logic rz, output logic busy_rdy);
      int g = 0;
      @(negedge clk);
      while (!in_ready && g < 200) begin @(negedge clk); g++; end
      op = o; a = xa; b = xb; in_valid = 1'b1;
      sb_q.push_back(model(o, xa, xb));
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 1; busy_rdy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_rdy = 1'b1;
         @(posedge clk); #1; lat++;
      end
      ry = y; rill = illegal; rz = zero;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if ({y, zero, illegal} !== {32'd0, 1'b1, 1'b0}) begin miscompares++; $display("FAIL reset_outputs got y=%h zero=%b ill=%b want 0/1/0", y, zero, illegal); end
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_table(input string name, input logic [4:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
      int lat; logic [31:0] ry; logic rill, rz, br; logic [32:0] e;
      foreach (ops[i]) begin
         run_op(ops[i], as[i], bs[i], lat, ry, rill, rz, br);
         e = sb_q.pop_front();
         vectors++; if ({rill, ry} !== e) begin miscompares++; $display("FAIL %s[%0d] op=%h got ill=%b y=%h want ill=%b y=%h", name, i, ops[i], rill, ry, e[32], e[31:0]); end
         vectors++; if (lat !== exp_lat(ops[i])) begin miscompares++; $display("FAIL %s_lat[%0d] got %0d want %0d", name, i, lat, exp_lat(ops[i])); end
         vectors++; if (rz !== (e[31:0] == 0)) begin miscompares++; $display("FAIL %s_zero[%0d] got %b want %b", name, i, rz, e[31:0] == 0); end
         if (exp_lat(ops[i]) > 1) begin
            vectors++; if (br !== 1'b0) begin miscompares++; $display("FAIL %s_busy_ready[%0d] got 1 want 0", name, i); end
         end
      end
   endtask

   task automatic test_base();
      logic [4:0]  o[] = '{5'h00, 5'h08, 5'h09, 5'h01, 5'h05, 5'h06, 5'h07, 5'h04};
      logic [31:0] x[] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hF000_0000, 32'hAAAA_5555};
      logic [31:0] z[] = '{32'd1, 32'h21, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0000_001F, 32'h24, 32'hFFFF_0000};
      test_table("base", o, x, z);
   endtask

   task automatic test_mul();
      logic [4:0]  o[] = '{5'h10, 5'h11, 5'h12, 5'h12, 5'h11, 5'h10};
      logic [31:0] x[] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h1234_5678};
      logic [31:0] z[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'd0};
      test_table("mul", o, x, z);
   endtask

   task automatic test_divide();
      logic [4:0]  o[] = '{5'h13, 5'h15, 5'h14, 5'h15, 5'h13, 5'h15, 5'h13, 5'h16};
      logic [31:0] x[] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100};
      logic [31:0] z[] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd7};
      test_table("div", o, x, z);
   endtask

   task automatic test_illegal();
      logic [4:0]  o[] = '{5'h1F, 5'h00, 5'h0A};
      logic [31:0] x[] = '{32'h1234, 32'd2, 32'd9};
      logic [31:0] z[] = '{32'h5678, 32'd3, 32'd9};
      test_table("illegal", o, x, z);
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] ry; logic rill, rz, br; logic [32:0] e;
      @(posedge clk); #1;
      out_ready = 1'b0;
      run_op(5'h00, 32'd3, 32'd4, lat, ry, rill, rz, br);
      e = sb_q.pop_front();
      vectors++; if ({rill, ry} !== e) begin miscompares++; $display("FAIL bp_result got %h want %h", ry, e[31:0]); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0]; op = 5'h01; a = 32'd100; b = 32'd1;
         @(posedge clk); #1;
         vectors++; if ({out_valid, in_ready, illegal, y} !== {1'b1, 1'b0, e}) begin miscompares++; $display("FAIL bp_hold[%0d] got v=%b r=%b y=%h want v=1 r=0 y=%h", i, out_valid, in_ready, y, e[31:0]); end
      end
      @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
      @(posedge clk); #1;
      vectors++; if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
      @(posedge clk); #1;
      vectors++; if ({out_valid, in_ready, y} !== {2'b01, e[31:0]}) begin miscompares++; $display("FAIL bp_no_stray got v=%b r=%b y=%h want v=0 r=1 y=%h", out_valid, in_ready, y, e[31:0]); end
   endtask

   task automatic test_reset_mid_div();
      int seen = 0;
      @(posedge clk); #1;
      @(negedge clk) begin op = 5'h13; a = 32'd1000; b = 32'd3; in_valid = 1'b1; end
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      vectors++; if ({out_valid, in_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_div_during got v=%b r=%b want 0/0", out_valid, in_ready); end
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      vectors++; if ({out_valid, in_ready, y} !== {2'b01, 32'd0}) begin miscompares++; $display("FAIL rst_div_after got v=%b r=%b y=%h want v=0 r=1 y=0", out_valid, in_ready, y); end
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_div_no_pulse got %0d out_valid cycles want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] ry; logic rill, rz, br; logic [32:0] e; logic [4:0] o;
      logic [4:0] pick[] = '{5'h00, 5'h01, 5'h05, 5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h1C};
      for (int i = 0; i < 24; i++) begin
         o = pick[$urandom_range(0, pick.size() - 1)];
         run_op(o, $urandom, (i % 5 == 0) ? 32'd0 : $urandom, lat, ry, rill, rz, br);
         e = sb_q.pop_front();
         vectors++; if ({rill, ry} !== e) begin miscompares++; $display("FAIL b2b[%0d] op=%h got ill=%b y=%h want ill=%b y=%h", i, o, rill, ry, e[32], e[31:0]); end
         vectors++; if (lat !== exp_lat(o)) begin miscompares++; $display("FAIL b2b_lat[%0d] got %0d want %0d", i, lat, exp_lat(o)); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_done_ready[%0d] got %b want 0", i, in_ready); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_base();
      test_mul();
      test_divide();
      test_illegal();
      test_backpressure();
      test_reset_mid_div();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
